// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D-cache memory port arbiter.
// Widths, FSM state encoding, requester IDs and the block-alignment helper.
package mem_port_arbiter_pkg;

    localparam int unsigned WORD_SIZE  = 16;
    localparam int unsigned FETCH_SIZE = 64;

    typedef enum logic [1:0] {
        ArbIdle   = 2'd0,
        ArbAccess = 2'd1,
        ArbResp   = 2'd2
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // A fetch returns four words, so read addresses point at the block base.
    function automatic logic [WORD_SIZE-1:0] block_align(input logic [WORD_SIZE-1:0] addr);
        return {addr[WORD_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of cache request/response and memory-port signals around the arbiter.
// master = arbiter side, slave = caches plus main memory.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic                  i_req_rd;
    logic [WORD_SIZE-1:0]  i_addr;
    logic                  i_ack;
    logic [FETCH_SIZE-1:0] i_rdata;

    logic                  d_req_rd;
    logic                  d_req_wr;
    logic [WORD_SIZE-1:0]  d_addr;
    logic [WORD_SIZE-1:0]  d_wdata;
    logic                  d_ack;
    logic [FETCH_SIZE-1:0] d_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [WORD_SIZE-1:0]  mem_addr;
    logic [WORD_SIZE-1:0]  mem_wdata;
    logic [FETCH_SIZE-1:0] mem_rdata;

    logic                  busy;
    logic                  grant_d;

    modport master (
        input  i_req_rd, i_addr, d_req_rd, d_req_wr, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_read, mem_write, mem_addr, mem_wdata,
        output busy, grant_d
    );

    modport slave (
        output i_req_rd, i_addr, d_req_rd, d_req_wr, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_read, mem_write, mem_addr, mem_wdata,
        input  busy, grant_d
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick between the I-cache and D-cache.
// On a tie the requester that was not granted last wins.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic req_icache,
    input  logic req_dcache,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req_icache | req_dcache;
        grant_id    = REQ_I;
        if (req_icache && req_dcache) begin
            grant_id = ~last_grant;
        end else if (req_dcache) begin
            grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit-fetch memory port between I-cache reads and D-cache reads/writes.
// Latches the winner's request, holds memory for MEM_LATENCY cycles, then acks for one cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4
) (
    input logic                clk,
    input logic                reset_n,
    mem_port_arbiter_if.master bus
);

    localparam int unsigned     CntW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(MEM_LATENCY - 1);

    arb_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [WORD_SIZE-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
    logic [FETCH_SIZE-1:0] resp_data_q, resp_data_d;

    logic d_req;
    logic grant_valid;
    logic grant_id;

    assign d_req = bus.d_req_rd | bus.d_req_wr;

    rr_arbiter2 u_rr_arbiter2 (
        .req_icache  (bus.i_req_rd),
        .req_dcache  (d_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_data_d  = resp_data_q;

        case (state_q)
            ArbIdle: begin
                if (grant_valid) begin
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = CntInit;
                    state_d      = ArbAccess;
                    if (grant_id == REQ_D) begin
                        mem_wdata_d = bus.d_wdata;
                        // A simultaneous read+write request is served as the write.
                        if (bus.d_req_wr) begin
                            mem_write_d = 1'b1;
                            mem_addr_d  = bus.d_addr;
                        end else begin
                            mem_read_d = 1'b1;
                            mem_addr_d = block_align(bus.d_addr);
                        end
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = block_align(bus.i_addr);
                    end
                end
            end
            ArbAccess: begin
                if (cnt_q == '0) begin
                    if (mem_read_q) begin
                        resp_data_d = bus.mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = ArbResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ArbResp: begin
                state_d = ArbIdle;
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ArbIdle;
            cnt_q        <= '0;
            last_grant_q <= REQ_I;
            owner_q      <= REQ_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.i_ack     = (state_q == ArbResp) && (owner_q == REQ_I);
    assign bus.d_ack     = (state_q == ArbResp) && (owner_q == REQ_D);
    assign bus.i_rdata   = resp_data_q;
    assign bus.d_rdata   = resp_data_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != ArbIdle);
    assign bus.grant_d   = owner_q;

endmodule
